// File: rtl/kb_scancode_decoder.sv
// kb_scancode_decoder: strips PS/2 E0/F0 prefixes into {ext, brk, code} events,
// queues them in a small FIFO and tracks shift-key state.
module kb_scancode_decoder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [9:0] evt_data,
    output logic       evt_valid,
    input  logic       evt_rd,
    output logic       shift_held,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       proto_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);
    // bit 0 = extended prefix seen, bit 1 = break prefix seen
    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] EXT     = 2'b01;
    localparam logic [1:0] BRK     = 2'b10;
    localparam logic [1:0] EXT_BRK = 2'b11;

    logic [1:0]    state, state_n;
    logic [TW-1:0] tcnt;
    logic          filt, is_e0, is_f0, tmo, push, err;
    logic          pv;
    logic [9:0]    pd;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, pop, drop, wr;
    logic          lsh, rsh;

    always_comb begin
        filt    = byte_in inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
        is_e0   = byte_in == 8'hE0;
        is_f0   = byte_in == 8'hF0;
        tmo     = state != IDLE && tcnt == TW'(TIMEOUT_CYC - 1);
        state_n = state;
        push    = 1'b0;
        err     = 1'b0;
        if (byte_valid) begin
            if (filt) begin
                state_n = IDLE;
            end else if (state == IDLE) begin
                state_n = is_e0 ? EXT : is_f0 ? BRK : IDLE;
                push    = !is_e0 && !is_f0;
            end else if (state == EXT) begin
                state_n = is_e0 ? EXT : is_f0 ? EXT_BRK : IDLE;
                push    = !is_e0 && !is_f0;
            end else begin
                state_n = IDLE;
                push    = !is_e0 && !is_f0;
                err     = is_e0 || is_f0;
            end
        end else if (tmo) begin
            state_n = IDLE;
            err     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tcnt      <= '0;
            pv        <= 1'b0;
            pd        <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_n;
            tcnt      <= (byte_valid || state_n == IDLE) ? '0 : tcnt + TW'(1);
            pv        <= push;
            pd        <= {state[0], state[1], byte_in};
            proto_err <= err;
        end
    end

    assign full = count == CW'(FIFO_DEPTH);
    assign pop  = evt_rd && count != '0;
    assign drop = pv && full && !pop;
    assign wr   = pv && !drop;

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= pd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            lsh      <= 1'b0;
            rsh      <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count    <= count + CW'(wr) - CW'(pop);
            overflow <= drop | (overflow & ~ovf_clr);
            // shift tracking follows every decoded event, even one dropped on overflow
            if (pv && !pd[9] && pd[7:0] == 8'h12) lsh <= !pd[8];
            if (pv && !pd[9] && pd[7:0] == 8'h59) rsh <= !pd[8];
        end
    end

    assign evt_valid  = count != '0;
    assign evt_data   = evt_valid ? mem[rd_ptr] : '0;
    assign shift_held = lsh | rsh;
endmodule

// File: tb/tb_kb_scancode_decoder.sv
// tb_kb_scancode_decoder: directed stimulus checked every cycle against a
// prefix/queue reference model, plus literal expectations.
module tb_kb_scancode_decoder;
    localparam int DEPTH = 4;
    localparam int TO    = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic [9:0] evt_data;
    logic       evt_valid;
    logic       evt_rd = 1'b0;
    logic       shift_held;
    logic       overflow;
    logic       ovf_clr = 1'b0;
    logic       proto_err;

    kb_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .evt_data(evt_data), .evt_valid(evt_valid), .evt_rd(evt_rd),
        .shift_held(shift_held), .overflow(overflow), .ovf_clr(ovf_clr),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int perr_cnt = 0;
    int p0;
    bit run = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: pending prefix flags, a one-cycle staging slot, and a queue
    logic [9:0] m_q[$];
    logic [9:0] m_stg = '0;
    logic [9:0] m_tmp;
    bit m_stg_v = 0, m_ext = 0, m_brk = 0, m_lsh = 0, m_rsh = 0, m_ovf = 0, m_perr = 0;
    bit m_full, m_pop, m_drop, m_err;
    int m_idle = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_stg_v = 0; m_ext = 0; m_brk = 0; m_idle = 0;
            m_lsh = 0; m_rsh = 0; m_ovf = 0; m_perr = 0;
        end else begin
            m_full = m_q.size() == DEPTH;
            m_pop  = evt_rd && m_q.size() != 0;
            m_drop = m_stg_v && m_full && !m_pop;
            if (m_pop) m_tmp = m_q.pop_front();
            if (m_stg_v) begin
                if (!m_stg[9] && m_stg[7:0] == 8'h12) m_lsh = !m_stg[8];
                if (!m_stg[9] && m_stg[7:0] == 8'h59) m_rsh = !m_stg[8];
                if (!m_drop) m_q.push_back(m_stg);
            end
            if (m_drop) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            m_err = 0;
            m_stg_v = 0;
            if (byte_valid) begin
                m_idle = 0;
                if (byte_in inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
                    m_ext = 0; m_brk = 0;
                end else if (byte_in == 8'hE0 || byte_in == 8'hF0) begin
                    if (m_brk) begin m_err = 1; m_ext = 0; m_brk = 0; end
                    else if (byte_in == 8'hE0) m_ext = 1;
                    else m_brk = 1;
                end else begin
                    m_stg = {m_ext, m_brk, byte_in};
                    m_stg_v = 1; m_ext = 0; m_brk = 0;
                end
            end else if (m_ext || m_brk) begin
                m_idle++;
                if (m_idle == TO) begin m_err = 1; m_ext = 0; m_brk = 0; m_idle = 0; end
            end
            m_perr = m_err;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("evt_valid", 32'(evt_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) chk("evt_data", 32'(evt_data), 32'(m_q[0]));
            chk("shift_held", 32'(shift_held), 32'(m_lsh | m_rsh));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("proto_err", 32'(proto_err), 32'(m_perr));
            if (proto_err === 1'b1) perr_cnt++;
        end
    end

    // all tasks start and end just after a falling edge
    task automatic send(input logic [7:0] b);
        byte_in = b; byte_valid = 1'b1;
        @(negedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic pop_chk(input string name, input logic [9:0] exp);
        chk(name, {21'b0, evt_valid, evt_data}, {21'b0, 1'b1, exp});
        evt_rd = 1'b1;
        @(negedge clk); #1;
        evt_rd = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk); #1;
        run = 1'b1;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_data", 32'(evt_data), 32'd0);
        chk("rst_shift", 32'(shift_held), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);
        rst_n = 1'b1;
        idle(1);

        send(8'h1C); send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hF0); send(8'h1C);
        idle(2);
        pop_chk("seq0", 10'h01C); pop_chk("seq1", 10'h275);
        pop_chk("seq2", 10'h375); pop_chk("seq3", 10'h11C);
        chk("seq_empty", 32'(evt_valid), 32'd0);

        evt_rd = 1'b1;
        send(8'h12); send(8'h59); send(8'hF0); send(8'h12); idle(1);
        chk("shift_one_left", 32'(shift_held), 32'd1);
        send(8'hF0); send(8'h59); idle(1);
        chk("shift_released", 32'(shift_held), 32'd0);
        send(8'h12); send(8'hE0); send(8'hF0); send(8'h12); idle(1);
        chk("shift_ext_brk", 32'(shift_held), 32'd1);
        send(8'hF0); send(8'h12); send(8'hE0); send(8'h12); idle(1);
        chk("shift_ext_make", 32'(shift_held), 32'd0);
        idle(2);
        evt_rd = 1'b0;

        for (int i = 0; i < 5; i++) send(8'h15 + 8'(i));
        idle(2);
        chk("ovf_set", 32'(overflow), 32'd1);
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);
        pop_chk("ovf0", 10'h015);
        send(8'h1A); send(8'h1B);
        evt_rd = 1'b1; idle(1); evt_rd = 1'b0;
        chk("full_pop_push", 32'(overflow), 32'd0);
        pop_chk("ovf1", 10'h017); pop_chk("ovf2", 10'h018);
        pop_chk("ovf3", 10'h01A); pop_chk("ovf4", 10'h01B);
        for (int i = 0; i < 5; i++) send(8'h20 + 8'(i));
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        ovf_clr = 1'b1; evt_rd = 1'b1; idle(6); ovf_clr = 1'b0; evt_rd = 1'b0;
        chk("drain", 32'(evt_valid), 32'd0);

        p0 = perr_cnt;
        send(8'hE0); idle(TO + 3);
        chk("timeout_pulses", 32'(perr_cnt - p0), 32'd1);
        send(8'h1C); idle(1);
        pop_chk("after_timeout", 10'h01C);
        p0 = perr_cnt;
        send(8'hE0); idle(TO - 1); send(8'h75); idle(3);
        chk("timeout_suppressed", 32'(perr_cnt - p0), 32'd0);
        pop_chk("late_ext", 10'h275);

        p0 = perr_cnt;
        send(8'hF0); send(8'hE0); idle(2);
        chk("brk_prefix_err", 32'(perr_cnt - p0), 32'd1);
        chk("brk_prefix_noevt", 32'(evt_valid), 32'd0);
        p0 = perr_cnt;
        send(8'hE0); send(8'hAA); send(8'h1C); idle(1);
        pop_chk("filt_aa", 10'h01C);
        send(8'hF0); send(8'hFA); send(8'h1C); idle(1);
        pop_chk("filt_fa", 10'h01C);
        send(8'hAA); send(8'hFA); idle(2);
        chk("filt_noevt", 32'(evt_valid), 32'd0);
        chk("filt_noerr", 32'(perr_cnt - p0), 32'd0);

        send(8'hF0);
        rst_n = 1'b0; idle(2); rst_n = 1'b1;
        send(8'h1C); idle(1);
        pop_chk("after_reset", 10'h01C);
        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
